avr_uart: RTL

AVR_UART -- requirements
Module: avr_uart

---
 rtl/avr_uart.sv | 315 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/avr_uart.sv
// avr_uart: IO-mapped 8N1 UART with a 16x baud tick, a 4-deep TX FIFO,
// a single-byte RX buffer with overrun/framing flags, and a level interrupt.
module avr_uart #(
  parameter logic [5:0] BASE      = 6'h0C,
  parameter logic [7:0] DIV_RESET = 8'd12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [5:0] io_a,
  input  logic [7:0] io_di,
  output logic [7:0] io_do,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // Register decode
  logic sel_udr, sel_usr, sel_ubrr;
  logic udr_rd, usr_rd, udr_wr, usr_wr, ubrr_wr;

  assign sel_udr  = (io_a == BASE);
  assign sel_usr  = (io_a == BASE + 6'd1);
  assign sel_ubrr = (io_a == BASE + 6'd2);
  assign udr_rd   = io_re & sel_udr;
  assign usr_rd   = io_re & sel_usr;
  assign udr_wr   = io_we & sel_udr;
  assign usr_wr   = io_we & sel_usr;
  assign ubrr_wr  = io_we & sel_ubrr;

  // Status / control state
  logic [7:0] ubrr;
  logic       rxc, ovr, fe, rxie, txie;
  logic [7:0] rbuf;

  // Baud tick generator
  logic [7:0] cnt;
  logic       tick;
  assign tick = (cnt == 8'd0);

  // Down-counter reloads from UBRR at zero, so a new divisor applies at the next reload
  always_ff @(posedge clk) begin
    if (rst)       cnt <= DIV_RESET;
    else if (tick) cnt <= ubrr;
    else           cnt <= cnt - 8'd1;
  end

  // TX FIFO
  logic [7:0] fifo_mem [4];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic       fifo_empty, txe, push, pop;
  logic [7:0] fifo_head;

  assign fifo_empty = (count == 3'd0);
  assign txe        = (count != 3'd4);
  // A pop in the same cycle frees the slot, so a push on a full FIFO is accepted then
  assign push       = udr_wr & (txe | pop);
  assign fifo_head  = fifo_mem[rp];

  // FIFO storage, written at the write pointer
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wp] <= io_di;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      count <= 3'd0;
    end else begin
      if (push) wp <= wp + 2'd1;
      if (pop)  rp <= rp + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // TX FSM
  tx_state_t  tx_state, tx_state_n;
  logic [3:0] tx_tcnt, tx_tcnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       tx_line, tx_line_n;
  logic       tx_idle;

  assign tx_idle = fifo_empty & (tx_state == TX_IDLE);
  assign uart_tx = tx_line;

  // TX state register; the serial line is registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_tcnt  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bit   <= tx_bit_n;
      tx_line  <= tx_line_n;
    end
  end

  // TX shift register holds the byte in flight
  always_ff @(posedge clk) begin
    tx_shift <= tx_shift_n;
  end

  // TX next state: 16 ticks per bit, STOP chains straight into START when more data waits
  always_comb begin
    tx_state_n = tx_state;
    tx_tcnt_n  = tx_tcnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = tx_line;
    pop        = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (tick && !fifo_empty) begin
          pop        = 1'b1;
          tx_shift_n = fifo_head;
          tx_tcnt_n  = 4'd0;
          tx_state_n = TX_START;
          tx_line_n  = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          tx_tcnt_n = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            tx_bit_n   = 3'd0;
            tx_state_n = TX_DATA;
            tx_line_n  = tx_shift[0];
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          tx_tcnt_n = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (tx_bit == 3'd7) begin
              tx_state_n = TX_STOP;
              tx_line_n  = 1'b1;
            end else begin
              tx_bit_n   = tx_bit + 3'd1;
              tx_shift_n = {1'b0, tx_shift[7:1]};
              tx_line_n  = tx_shift[1];
            end
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          tx_tcnt_n = tx_tcnt + 4'd1;
          if (tx_tcnt == 4'd15) begin
            if (!fifo_empty) begin
              pop        = 1'b1;
              tx_shift_n = fifo_head;
              tx_state_n = TX_START;
              tx_line_n  = 1'b0;
            end else begin
              tx_state_n = TX_IDLE;
              tx_line_n  = 1'b1;
            end
          end
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_line_n  = 1'b1;
      end
    endcase
  end

  // RX path
  logic       rx_s1, rx_s2;
  rx_state_t  rx_state, rx_state_n;
  logic [3:0] rx_tcnt, rx_tcnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       rx_done, rx_load;

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= 4'd0;
      rx_bit   <= 3'd0;
    end else begin
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bit   <= rx_bit_n;
    end
  end

  // RX shift register collects data bits LSB first
  always_ff @(posedge clk) begin
    rx_shift <= rx_shift_n;
  end

  // RX next state: mid-bit check of START rejects glitches, then one sample per 16 ticks
  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_tcnt_n  = 4'd0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd7) begin
            rx_tcnt_n  = 4'd0;
            rx_bit_n   = 3'd0;
            rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_shift_n = {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state_n = RX_STOP;
            else                rx_bit_n   = rx_bit + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          rx_tcnt_n = rx_tcnt + 4'd1;
          if (rx_tcnt == 4'd15) begin
            rx_done    = 1'b1;
            rx_state_n = RX_IDLE;
          end
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // A completed byte loads when the buffer is free or is being read in the same cycle
  assign rx_load = rx_done & (~rxc | udr_rd);

  // Receive buffer data
  always_ff @(posedge clk) begin
    if (rx_load) rbuf <= rx_shift;
  end

  // Status flags, interrupt enables, divisor and the registered interrupt request
  always_ff @(posedge clk) begin
    if (rst) begin
      rxc  <= 1'b0;
      ovr  <= 1'b0;
      fe   <= 1'b0;
      rxie <= 1'b0;
      txie <= 1'b0;
      ubrr <= DIV_RESET;
      irq  <= 1'b0;
    end else begin
      if (rx_load) begin
        rxc <= 1'b1;
        fe  <= ~rx_s2;
      end else if (udr_rd) begin
        rxc <= 1'b0;
      end
      if (rx_done && rxc && !udr_rd) ovr <= 1'b1;
      else if (usr_rd)               ovr <= 1'b0;
      if (usr_wr) begin
        rxie <= io_di[6];
        txie <= io_di[7];
      end
      if (ubrr_wr) ubrr <= io_di;
      irq <= (rxie & rxc) | (txie & txe);
    end
  end

  // Read mux, zero unless a UART register is being read
  always_comb begin
    io_do = 8'h00;
    if (io_re) begin
      if (sel_udr)       io_do = rbuf;
      else if (sel_usr)  io_do = {txie, rxie, 1'b0, fe, ovr, tx_idle, txe, rxc};
      else if (sel_ubrr) io_do = ubrr;
    end
  end

endmodule
